// File: rtl/adder_rr_scheduler_pkg.sv
// Shared constants and the result-slot state encoding for the shared-adder scheduler.
// No logic lives here.
package adder_rr_scheduler_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/adder_8bit.sv
// 8-bit adder with the carry kept as bit 8.
// Purely combinational; there is no backpressure.
module adder_8bit (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [8:0] sum_o
);

    assign sum_o = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/adder_rr_scheduler_rr_pick.sv
// Rotating-priority picker: grants the first set request at or after ptr, wrapping at N-1.
// Purely combinational; there is no backpressure.
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [N-1:0]    grant_o,
    output logic [ID_W-1:0] idx_o
);

    int               c;
    logic             found;
    logic [ID_W-1:0]  cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        c       = 0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            // Explicit wrap so that a non-power-of-two N never indexes past N-1.
            c = int'(ptr_i) + i;
            if (c >= N) c = c - N;
            cand = ID_W'(c);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/adder_rr_scheduler.sv
// Shares one 8-bit adder among NUM_REQ requesters with round-robin arbitration and a one-entry result slot.
// Latency is one cycle from accept to rsp_valid, and a full slot with rsp_ready low blocks every grant.
module adder_rr_scheduler
    import adder_rr_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    output logic [WIDTH:0]           rsp_sum,
    output logic [ID_W-1:0]          rsp_id,
    input  logic                     rsp_ready,
    output logic [CNT_W-1:0]         op_count
);

    state_e             state_q;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [WIDTH:0]     rsp_sum_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [CNT_W-1:0]   op_count_q;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gidx;
    logic               can_accept;
    logic               accept;
    logic [WIDTH-1:0]   sel_a, sel_b;
    logic [WIDTH:0]     sum_d;

    rr_pick #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (gidx)
    );

    assign can_accept = (state_q == ST_IDLE) || rsp_ready;
    assign req_ready  = (rst_n && can_accept) ? grant : '0;
    assign accept     = |req_ready;

    // AND-OR operand mux keeps req_ready independent of operand values.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a = sel_a | req_a[i*WIDTH +: WIDTH];
                sel_b = sel_b | req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    adder_8bit u_add (
        .a_i   (sel_a),
        .b_i   (sel_b),
        .sum_o (sum_d)
    );

    assign rr_ptr_d = (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + ID_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            rsp_sum_q  <= '0;
            rsp_id_q   <= '0;
            op_count_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q    <= ST_HOLD;
                        rsp_sum_q  <= sum_d;
                        rsp_id_q   <= gidx;
                        rr_ptr_q   <= rr_ptr_d;
                        op_count_q <= op_count_q + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (accept) begin
                        rsp_sum_q  <= sum_d;
                        rsp_id_q   <= gidx;
                        rr_ptr_q   <= rr_ptr_d;
                        op_count_q <= op_count_q + CNT_W'(1);
                    end else if (rsp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = (state_q == ST_HOLD);
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Bench for adder_rr_scheduler: constant vector table, hand sequences and a randomized run
// against a queue-free slot model that follows the round-robin rules directly.
module tb_adder_rr_scheduler;

    localparam int NR = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_a, req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [8:0]  rsp_sum;
    logic [1:0]  rsp_id;
    logic        rsp_ready;
    logic [15:0] op_count;

    always #5 clk = ~clk;

    adder_rr_scheduler #(.NUM_REQ(NR), .WIDTH(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .op_count  (op_count)
    );

    int tests = 0;
    int fails = 0;

    // Reference model of the slot
    int m_ptr, m_valid, m_sum, m_id, m_cnt;
    int last_g;
    logic [3:0] cap_rdy;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_grant(input logic [3:0] v);
        for (int k = 0; k < NR; k++) begin
            if (v[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        end
        return -1;
    endfunction

    function automatic int lane(input logic [31:0] x, input int i);
        return int'((x >> (8 * i)) & 32'hFF);
    endfunction

    // One clock cycle, entered just after a falling edge.
    task automatic cycle(input logic rst, input logic [3:0] v, input logic [31:0] a,
                         input logic [31:0] b, input logic rr);
        int g;
        int exp_rdy;
        rst_n = rst; req_valid = v; req_a = a; req_b = b; rsp_ready = rr;
        #1;
        g = -1;
        if (rst && (m_valid == 0 || rr)) g = model_grant(v);
        exp_rdy = (g >= 0) ? (1 << g) : 0;
        cap_rdy = req_ready;
        chk("req_ready", int'(req_ready), exp_rdy);
        @(posedge clk);
        if (!rst) begin
            m_ptr = 0; m_valid = 0; m_sum = 0; m_id = 0; m_cnt = 0;
        end else if (g >= 0) begin
            m_sum = lane(a, g) + lane(b, g);
            m_id = g; m_valid = 1;
            m_ptr = (g + 1) % NR;
            m_cnt = (m_cnt + 1) % 65536;
        end else if (m_valid == 1 && rr) begin
            m_valid = 0;
        end
        last_g = g;
        @(negedge clk);
        chk("rsp_valid", int'(rsp_valid), m_valid);
        chk("rsp_sum", int'(rsp_sum), m_sum);
        chk("rsp_id", int'(rsp_id), m_id);
        chk("op_count", int'(op_count), m_cnt);
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [31:0] a;
        logic [31:0] b;
        logic        rr;
        logic [3:0]  e_rdy;
        logic        e_vld;
        logic [8:0]  e_sum;
        logic [1:0]  e_id;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a4, b4, ao, bo;
        logic [8:0]  s_sum;
        logic [1:0]  s_id;
        int          order[6];

        a4 = {8'd40, 8'd30, 8'd20, 8'd10};
        b4 = {8'd4, 8'd3, 8'd2, 8'd1};
        ao = {8'd40, 8'd30, 8'd20, 8'd255};
        bo = {8'd4, 8'd3, 8'd2, 8'd255};

        tbl[0]  = '{1'b0, 4'hF, a4, b4, 1'b1, 4'h0, 1'b0, 9'd0,   2'd0, 16'd0};
        tbl[1]  = '{1'b0, 4'hF, a4, b4, 1'b1, 4'h0, 1'b0, 9'd0,   2'd0, 16'd0};
        tbl[2]  = '{1'b0, 4'hF, a4, b4, 1'b1, 4'h0, 1'b0, 9'd0,   2'd0, 16'd0};
        tbl[3]  = '{1'b1, 4'b0100, {8'd0, 8'd200, 16'd0}, {8'd0, 8'd100, 16'd0}, 1'b1,
                    4'b0100, 1'b1, 9'd300, 2'd2, 16'd1};
        tbl[4]  = '{1'b1, 4'b0000, a4, b4, 1'b1, 4'b0000, 1'b0, 9'd300, 2'd2, 16'd1};
        tbl[5]  = '{1'b1, 4'b1111, a4, b4, 1'b1, 4'b1000, 1'b1, 9'd44,  2'd3, 16'd2};
        tbl[6]  = '{1'b1, 4'b1111, a4, b4, 1'b1, 4'b0001, 1'b1, 9'd11,  2'd0, 16'd3};
        tbl[7]  = '{1'b1, 4'b1111, a4, b4, 1'b0, 4'b0000, 1'b1, 9'd11,  2'd0, 16'd3};
        tbl[8]  = '{1'b1, 4'b1010, a4, b4, 1'b0, 4'b0000, 1'b1, 9'd11,  2'd0, 16'd3};
        tbl[9]  = '{1'b1, 4'b1010, a4, b4, 1'b1, 4'b0010, 1'b1, 9'd22,  2'd1, 16'd4};
        tbl[10] = '{1'b1, 4'b1010, a4, b4, 1'b1, 4'b1000, 1'b1, 9'd44,  2'd3, 16'd5};
        tbl[11] = '{1'b1, 4'b0001, ao, bo, 1'b1, 4'b0001, 1'b1, 9'h1FE, 2'd0, 16'd6};

        m_ptr = 0; m_valid = 0; m_sum = 0; m_id = 0; m_cnt = 0; last_g = -1;
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].rst, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].rr);
            chk($sformatf("tbl%0d_rdy", i), int'(cap_rdy), int'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_vld", i), int'(rsp_valid), int'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_sum", i), int'(rsp_sum), int'(tbl[i].e_sum));
            chk($sformatf("tbl%0d_id", i), int'(rsp_id), int'(tbl[i].e_id));
            chk($sformatf("tbl%0d_cnt", i), int'(op_count), int'(tbl[i].e_cnt));
        end

        // Mid-operation reset while the slot is full and stalled
        cycle(1'b1, 4'b0010, a4, b4, 1'b0);
        chk("midrst_hold_vld", int'(rsp_valid), 1);
        cycle(1'b0, 4'b1111, a4, b4, 1'b0);
        chk("midrst_vld", int'(rsp_valid), 0);
        chk("midrst_cnt", int'(op_count), 0);

        // Fairness from a fresh pointer: 0,1,2,3,0,1 without bubbles
        order = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 4'b1111, a4, b4, 1'b1);
            chk($sformatf("fair%0d_rdy", i), int'(cap_rdy), 1 << order[i]);
            chk($sformatf("fair%0d_sum", i), int'(rsp_sum), 11 * (order[i] + 1));
            chk($sformatf("fair%0d_vld", i), int'(rsp_valid), 1);
        end

        // Backpressure: pointer is at 2 with requesters 1 and 3 waiting
        s_sum = rsp_sum; s_id = rsp_id;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 4'b1010, a4, b4, 1'b0);
            chk($sformatf("bp%0d_rdy", i), int'(cap_rdy), 0);
            chk($sformatf("bp%0d_sum", i), int'(rsp_sum), int'(s_sum));
            chk($sformatf("bp%0d_id", i), int'(rsp_id), int'(s_id));
        end
        cycle(1'b1, 4'b1010, a4, b4, 1'b1);
        chk("bp_release_rdy", int'(cap_rdy), 4'b1000);
        chk("bp_release_id", int'(rsp_id), 3);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) != 0), 4'($urandom), $urandom, $urandom,
                  ($urandom_range(0, 3) != 0));
        end

        // Counter wrap
        cycle(1'b0, 4'h0, a4, b4, 1'b1);
        for (int i = 0; i < 65535; i++) begin
            cycle(1'b1, 4'hF, ao, bo, 1'b1);
        end
        chk("cnt_ffff", int'(op_count), 16'hFFFF);
        cycle(1'b1, 4'hF, ao, bo, 1'b1);
        chk("cnt_wrap", int'(op_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
